tdm_demux4: RTL and testbench

Receive side of the team's 4:1 time-division link: recovers four 1-bit channels from a serial slot stream that a 4:1 multiplexer produces by stepping its 2-bit select 00→01→10→11 once per slot. The block tracks the slot position using a frame-sync marker on slot 0, stores each slot's bit, and presents all four channels in parallel once per frame. It sits at the link receiver, directly downstream of the serial line.

---
 rtl/tdm_pkg.sv | 22 ++
 rtl/slot_counter.sv | 38 +++
 rtl/tdm_demux4.sv | 161 ++++++++++++++++
 tb/tb_tdm_demux4.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4:1 TDM link.
// Slot codes match the transmit-side mux select values.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int SLOT_W  = 2;
  localparam int N_SLOTS = 4;
  localparam int MISS_W  = 4;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [MISS_W-1:0] miss_t;

  localparam slot_t SLOT0 = 2'b00;
  localparam slot_t SLOT1 = 2'b01;
  localparam slot_t SLOT2 = 2'b10;
  localparam slot_t SLOT3 = 2'b11;

endpackage

// File: rtl/slot_counter.sv
// Mod-4 slot position counter shared with the transmit select generator.
// Clear wins over load-to-1, which wins over increment.
module slot_counter
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en_i,
  input  logic  load1_i,
  input  logic  clr_i,
  output slot_t slot_o
);

  slot_t slot_q;
  slot_t slot_d;

  // Next slot: wraps naturally from 3 to 0.
  always_comb begin
    slot_d = slot_q;
    if (clr_i)
      slot_d = SLOT0;
    else if (load1_i)
      slot_d = SLOT1;
    else if (en_i)
      slot_d = slot_q + slot_t'(1);
  end

  // Slot register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      slot_q <= SLOT0;
    else
      slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: frame alignment,
// slot capture and parallel publication of four channels.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int N_LOSS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic D,
  input  logic sync,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic valid,
  output logic locked,
  output logic err
);

  localparam miss_t LOSS_AT = miss_t'(N_LOSS - 1);

  state_e     state_q, state_d;
  slot_t      slot;
  miss_t      miss_q, miss_d;
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] y_q, y_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       cnt_inc, cnt_ld, cnt_clr;

  logic misplaced, realign, missing;
  logic mid, last, lost;

  assign misplaced = sync && (slot != SLOT0);
  assign realign   = sync && (slot == SLOT0);
  assign missing   = !sync && (slot == SLOT0);
  assign mid       = !sync &&
                     ((slot == SLOT1) || (slot == SLOT2));
  assign last      = !sync && (slot == SLOT3);
  assign lost      = (miss_q >= LOSS_AT);

  slot_counter u_slot (
    .clk     (clk),
    .rst     (rst),
    .en_i    (cnt_inc),
    .load1_i (cnt_ld),
    .clr_i   (cnt_clr),
    .slot_o  (slot)
  );

  // Alignment state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= HUNT;
    else
      state_q <= state_d;
  end

  // Lock on a marker; drop lock after N_LOSS missing markers.
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        HUNT:   if (sync) state_d = LOCKED;
        LOCKED: if (missing && lost) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Capture, publication and anomaly decode for the current slot.
  always_comb begin
    shadow_d = shadow_q;
    y_d      = y_q;
    miss_d   = miss_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    cnt_inc  = 1'b0;
    cnt_ld   = 1'b0;
    cnt_clr  = 1'b0;
    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d[0] = D;
            cnt_ld      = 1'b1;
            miss_d      = '0;
          end
        end
        LOCKED: begin
          unique case (1'b1)
            misplaced: begin
              err_d       = 1'b1;
              shadow_d[0] = D;
              cnt_ld      = 1'b1;
              miss_d      = '0;
            end
            realign: begin
              shadow_d[0] = D;
              cnt_ld      = 1'b1;
              miss_d      = '0;
            end
            missing: begin
              err_d = 1'b1;
              if (lost) begin
                miss_d  = '0;
                cnt_clr = 1'b1;
              end else begin
                miss_d      = miss_q + miss_t'(1);
                shadow_d[0] = D;
                cnt_ld      = 1'b1;
              end
            end
            mid: begin
              if (slot == SLOT1)
                shadow_d[1] = D;
              else
                shadow_d[2] = D;
              cnt_inc = 1'b1;
            end
            last: begin
              y_d     = {D, shadow_q};
              valid_d = 1'b1;
              cnt_inc = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      miss_q   <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      miss_q   <= miss_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign Y0     = y_q[0];
  assign Y1     = y_q[1];
  assign Y2     = y_q[2];
  assign Y3     = y_q[3];
  assign valid  = valid_q;
  assign locked = (state_q == LOCKED);
  assign err    = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: frame-level model plus
// directed scenarios with literal expectations.
module tb_tdm_demux4;

  localparam int NL = 3;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;
  logic D    = 1'b0;
  logic sync = 1'b0;
  logic Y0, Y1, Y2, Y3, valid, locked, err;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.N_LOSS(NL)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .D      (D),
    .sync   (sync),
    .Y0     (Y0),
    .Y1     (Y1),
    .Y2     (Y2),
    .Y3     (Y3),
    .valid  (valid),
    .locked (locked),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Behavioural receiver: frame position as an integer,
  // captured bits in an array, publication of whole frames.
  bit       m_lock  = 0;
  int       m_pos   = 0;
  int       m_miss  = 0;
  bit       m_bits[4];
  bit [3:0] m_y     = '0;
  bit       m_valid = 0;
  bit       m_err   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lock = 0; m_pos = 0; m_miss = 0;
      m_y = '0; m_valid = 0; m_err = 0;
      foreach (m_bits[i]) m_bits[i] = 0;
    end else begin
      m_valid = 0;
      m_err   = 0;
      if (en) begin
        if (!m_lock) begin
          if (sync) begin
            m_bits[0] = D; m_pos = 1;
            m_miss = 0; m_lock = 1;
          end
        end else if (sync && m_pos != 0) begin
          m_err = 1; m_bits[0] = D;
          m_pos = 1; m_miss = 0;
        end else if (m_pos == 0) begin
          if (sync) begin
            m_bits[0] = D; m_pos = 1; m_miss = 0;
          end else begin
            m_err = 1;
            m_miss++;
            if (m_miss < NL) begin
              m_bits[0] = D; m_pos = 1;
            end else begin
              m_lock = 0; m_pos = 0; m_miss = 0;
            end
          end
        end else if (m_pos < 3) begin
          m_bits[m_pos] = D;
          m_pos++;
        end else begin
          m_y = {D, m_bits[2], m_bits[1], m_bits[0]};
          m_valid = 1;
          m_pos = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    checks++;
    if ({Y3, Y2, Y1, Y0, valid, locked, err} !==
        {m_y, m_valid, m_lock, m_err}) begin
      errors++;
      $display("FAIL cycle t=%0t: Y=%b%b%b%b v=%b l=%b e=%b want Y=%b v=%b l=%b e=%b",
               $time, Y3, Y2, Y1, Y0, valid, locked, err,
               m_y, m_valid, m_lock, m_err);
    end
  end

  task automatic lit(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input bit e, input bit d, input bit s);
    en = e; D = d; sync = s;
    @(negedge clk);
  endtask

  function automatic logic [7:0] outs();
    return {1'b0, Y3, Y2, Y1, Y0, valid, locked, err};
  endfunction

  function automatic logic [7:0] ybits();
    return {4'b0, Y3, Y2, Y1, Y0};
  endfunction

  initial begin
    bit [3:0] ch;

    @(negedge clk);
    lit("reset", outs(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drv(0, 0, 0);

    // Lock and decode: D=1,0,1,1 per frame
    for (int f = 0; f < 3; f++) begin
      drv(1, 1, 1);
      lit("lock_level", {7'b0, locked}, 8'h01);
      drv(1, 0, 0);
      drv(1, 1, 0);
      drv(1, 1, 0);
      lit("decode_valid", {7'b0, valid}, 8'h01);
      lit("decode_y", ybits(), 8'h0D);
    end

    // en gaps after slots 0 and 2
    drv(1, 1, 1);
    drv(0, 0, 0);
    drv(1, 0, 0);
    drv(1, 1, 0);
    drv(0, 0, 1);
    drv(0, 1, 0);
    lit("gap_no_valid", {7'b0, valid}, 8'h00);
    drv(1, 1, 0);
    lit("gap_valid", {6'b0, valid, err}, 8'h02);
    lit("gap_y", ybits(), 8'h0D);

    // Flywheel: two missing markers
    drv(1, 0, 0);
    lit("miss1", {6'b0, locked, err}, 8'h03);
    drv(1, 1, 0);
    drv(1, 1, 0);
    drv(1, 0, 0);
    lit("fly1_y", {3'b0, valid, Y3, Y2, Y1, Y0}, 8'h16);
    drv(1, 1, 0);
    lit("miss2", {6'b0, locked, err}, 8'h03);
    drv(1, 0, 0);
    drv(1, 0, 0);
    drv(1, 1, 0);
    lit("fly2_y", {3'b0, valid, Y3, Y2, Y1, Y0}, 8'h19);
    // Third miss drops lock
    drv(1, 1, 0);
    lit("miss3", {6'b0, locked, err}, 8'h01);
    drv(1, 0, 0);
    drv(1, 1, 0);
    drv(1, 1, 0);
    lit("lost_no_valid", {6'b0, valid, locked}, 8'h00);
    lit("lost_y_held", ybits(), 8'h09);
    // Relock
    drv(1, 1, 1);
    drv(1, 0, 0);
    drv(1, 1, 0);
    drv(1, 1, 0);
    lit("relock_y", {3'b0, valid, Y3, Y2, Y1, Y0}, 8'h1D);

    // Misplaced marker at slot 2
    drv(1, 1, 1);
    drv(1, 0, 0);
    drv(1, 0, 1);
    lit("misplaced", {5'b0, valid, locked, err}, 8'h03);
    drv(1, 1, 0);
    drv(1, 1, 0);
    drv(1, 0, 0);
    lit("realign_y", {3'b0, valid, Y3, Y2, Y1, Y0}, 8'h16);

    // Async reset mid-frame after slot 1
    drv(1, 1, 1);
    drv(1, 1, 0);
    #2 rst = 1'b1;
    #1 lit("async_rst", outs(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drv(1, 1, 0);
    drv(1, 0, 0);
    drv(1, 1, 0);
    drv(1, 1, 0);
    lit("post_rst", {6'b0, valid, locked}, 8'h00);

    // Random frames from a free-running 4:1 mux
    for (int f = 0; f < 64; f++) begin
      ch = 4'($urandom);
      for (int sel = 0; sel < 4; sel++)
        drv(1, ch[sel], sel == 0);
      lit("rand_frame", {3'b0, valid, Y3, Y2, Y1, Y0},
          {3'b0, 1'b1, ch});
    end

    drv(0, 0, 0);
    drv(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
